lms_adapt_ctrl: RTL

Adaptation controller for the receive equalizer (FSE + LMS + slicer). It sequences start-up: the pipeline fill, then coarse adaptation, then fine adaptation, then locked tracking. It drives the LMS enable, step size and tap-clear. It measures windowed mean error energy from the slicer error to declare lock, and it restarts adaptation on loss of lock or failure to converge.

---
 rtl/lms_adapt_ctrl.sv | 271 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/lms_adapt_ctrl.sv
// ---------------------------------------------------------------------------
// lms_adapt_ctrl
//
// Start-up and tracking sequencer for the receive equalizer LMS loop.
// Walks IDLE -> FILL -> COARSE -> FINE -> TRACK. It measures the windowed
// mean slicer-error energy to declare lock, and on non-convergence or loss
// of lock it goes through RECOVER, which pulses a tap reload before
// refilling the pipeline.
//
// Ports
//   clk           in   system clock
//   i_reset       in   synchronous, active-low reset
//   i_sym_valid   in   one-cycle strobe per baud
//   i_err_I/Q     in   signed slicer error, S(NBT_ERR, NBF_ERR), valid with strobe
//   i_freeze      in   level; halts adaptation and all counters
//   o_lms_en      out  LMS tap-update enable
//   o_lms_step    out  signed LMS step, S(NBT_LMS_STEP, NBT_LMS_STEP-1)
//   o_taps_clear  out  one-cycle pulse on RECOVER entry
//   o_locked      out  high only in TRACK
//   o_state       out  IDLE=0 FILL=1 COARSE=2 FINE=3 TRACK=4 RECOVER=5
//   o_err_energy  out  mean energy of the last completed window, unsigned
//
// All outputs are registered from the next-state logic, so they change on
// the same edge as the state register.
// ---------------------------------------------------------------------------
module lms_adapt_ctrl #(
   parameter int NBT_ERR      = 12,
   parameter int NBF_ERR      = 9,
   parameter int NBT_LMS_STEP = 12,
   parameter logic signed [NBT_LMS_STEP-1:0] STEP_COARSE = 12'sh010,
   parameter logic signed [NBT_LMS_STEP-1:0] STEP_FINE   = 12'sh001,
   parameter int NFILL        = 64,
   parameter int NCOARSE      = 4096,
   parameter int NWIN_LOG2    = 8,
   parameter int MAX_FINE_WIN = 64,
   parameter logic [2*NBT_ERR:0] THR_LOCK   = 25'd2621,
   parameter logic [2*NBT_ERR:0] THR_UNLOCK = 25'd10486
) (
   input  logic                           clk,
   input  logic                           i_reset,
   input  logic                           i_sym_valid,
   input  logic signed [NBT_ERR-1:0]      i_err_I,
   input  logic signed [NBT_ERR-1:0]      i_err_Q,
   input  logic                           i_freeze,
   output logic                           o_lms_en,
   output logic signed [NBT_LMS_STEP-1:0] o_lms_step,
   output logic                           o_taps_clear,
   output logic                           o_locked,
   output logic [2:0]                     o_state,
   output logic [2*NBT_ERR:0]             o_err_energy
);

   // Energy word: sum of two exact squares needs one bit above 2*NBT_ERR.
   localparam int E_W    = 2*NBT_ERR + 1;
   // Accumulator holds 2^NWIN_LOG2 energy words without overflow.
   localparam int ACC_W  = E_W + NWIN_LOG2;
   localparam int CNT_MAX = (NCOARSE > NFILL) ? NCOARSE : NFILL;
   localparam int CNT_W  = $clog2(CNT_MAX + 1);
   localparam int FW_W   = $clog2(MAX_FINE_WIN + 1);

   // Thresholds must be ordered and the error format must have an integer bit.
   if ((THR_UNLOCK <= THR_LOCK) || (NBF_ERR >= NBT_ERR)) begin : g_param_check
      $error("lms_adapt_ctrl: inconsistent threshold or error format parameters");
   end

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FILL    = 3'd1,
      ST_COARSE  = 3'd2,
      ST_FINE    = 3'd3,
      ST_TRACK   = 3'd4,
      ST_RECOVER = 3'd5
   } state_t;

   state_t                    r_state;
   logic [CNT_W-1:0]          r_sym_cnt;
   logic [NWIN_LOG2-1:0]      r_win_cnt;
   logic [FW_W-1:0]           r_fine_win;
   logic [ACC_W-1:0]          r_acc;
   logic [E_W-1:0]            r_energy;
   logic                      r_lms_en;
   logic signed [NBT_LMS_STEP-1:0] r_lms_step;
   logic                      r_taps_clear;
   logic                      r_locked;

   state_t                    w_state_nxt;
   logic [CNT_W-1:0]          w_sym_cnt_nxt;
   logic [NWIN_LOG2-1:0]      w_win_cnt_nxt;
   logic [FW_W-1:0]           w_fine_win_nxt;
   logic [ACC_W-1:0]          w_acc_nxt;
   logic [E_W-1:0]            w_energy_nxt;
   logic                      w_lms_en_nxt;
   logic signed [NBT_LMS_STEP-1:0] w_lms_step_nxt;
   logic                      w_taps_clear_nxt;
   logic                      w_locked_nxt;

   logic                      w_stb;
   logic                      w_win_last;
   logic signed [2*NBT_ERR-1:0] w_sq_i;
   logic signed [2*NBT_ERR-1:0] w_sq_q;
   logic [E_W-1:0]            w_e;
   logic [ACC_W-1:0]          w_acc_sum;
   logic [E_W-1:0]            w_mean;
   logic                      w_unused_acc_lsb;

   // A strobe coinciding with freeze is dropped entirely.
   assign w_stb      = i_sym_valid & ~i_freeze;
   assign w_win_last = &r_win_cnt;

   // Squares are non-negative and at most 2^(2*NBT_ERR-2), so the MSB is
   // always zero and zero-extension is exact.
   assign w_sq_i    = i_err_I * i_err_I;
   assign w_sq_q    = i_err_Q * i_err_Q;
   assign w_e       = {1'b0, w_sq_i} + {1'b0, w_sq_q};
   assign w_acc_sum = r_acc + ACC_W'(w_e);
   // Divide by the window length by dropping the low bits (truncation).
   assign w_mean    = w_acc_sum[ACC_W-1:NWIN_LOG2];
   assign w_unused_acc_lsb = &w_acc_sum[NWIN_LOG2-1:0];

   // Next-state, counter, accumulator and output decode.
   always_comb begin
      w_state_nxt      = r_state;
      w_sym_cnt_nxt    = r_sym_cnt;
      w_win_cnt_nxt    = r_win_cnt;
      w_fine_win_nxt   = r_fine_win;
      w_acc_nxt        = r_acc;
      w_energy_nxt     = r_energy;
      w_lms_en_nxt     = 1'b0;
      w_lms_step_nxt   = '0;
      w_taps_clear_nxt = 1'b0;
      w_locked_nxt     = 1'b0;

      case (r_state)
         ST_IDLE: begin
            w_state_nxt   = ST_FILL;
            w_sym_cnt_nxt = '0;
         end

         ST_FILL: begin
            if (w_stb) begin
               if (r_sym_cnt == CNT_W'(NFILL - 1)) begin
                  w_state_nxt   = ST_COARSE;
                  w_sym_cnt_nxt = '0;
               end else begin
                  w_sym_cnt_nxt = r_sym_cnt + CNT_W'(1);
               end
            end else begin
               w_sym_cnt_nxt = r_sym_cnt;
            end
         end

         ST_COARSE: begin
            if (w_stb) begin
               if (r_sym_cnt == CNT_W'(NCOARSE - 1)) begin
                  // FINE starts with a fresh window and fine-window budget.
                  w_state_nxt    = ST_FINE;
                  w_sym_cnt_nxt  = '0;
                  w_win_cnt_nxt  = '0;
                  w_acc_nxt      = '0;
                  w_fine_win_nxt = '0;
               end else begin
                  w_sym_cnt_nxt = r_sym_cnt + CNT_W'(1);
               end
            end else begin
               w_sym_cnt_nxt = r_sym_cnt;
            end
         end

         ST_FINE, ST_TRACK: begin
            if (w_stb) begin
               if (w_win_last) begin
                  w_energy_nxt  = w_mean;
                  w_acc_nxt     = '0;
                  w_win_cnt_nxt = '0;
                  if (r_state == ST_FINE) begin
                     if (w_mean < THR_LOCK) begin
                        w_state_nxt = ST_TRACK;
                     end else if (r_fine_win == FW_W'(MAX_FINE_WIN - 1)) begin
                        w_state_nxt    = ST_RECOVER;
                        w_fine_win_nxt = '0;
                     end else begin
                        w_fine_win_nxt = r_fine_win + FW_W'(1);
                     end
                  end else begin
                     // Strict compare: equal to the unlock threshold stays locked.
                     if (w_mean > THR_UNLOCK) begin
                        w_state_nxt = ST_RECOVER;
                     end else begin
                        w_state_nxt = ST_TRACK;
                     end
                  end
               end else begin
                  w_acc_nxt     = w_acc_sum;
                  w_win_cnt_nxt = r_win_cnt + NWIN_LOG2'(1);
               end
            end else begin
               w_acc_nxt = r_acc;
            end
         end

         ST_RECOVER: begin
            w_state_nxt   = ST_FILL;
            w_sym_cnt_nxt = '0;
         end

         default: begin
            w_state_nxt   = ST_IDLE;
            w_sym_cnt_nxt = '0;
         end
      endcase

      // Outputs follow the state being entered so they line up with o_state.
      case (w_state_nxt)
         ST_COARSE: begin
            w_lms_en_nxt   = ~i_freeze;
            w_lms_step_nxt = STEP_COARSE;
         end
         ST_FINE: begin
            w_lms_en_nxt   = ~i_freeze;
            w_lms_step_nxt = STEP_FINE;
         end
         ST_TRACK: begin
            w_lms_en_nxt   = ~i_freeze;
            w_lms_step_nxt = STEP_FINE;
            w_locked_nxt   = 1'b1;
         end
         ST_RECOVER: begin
            w_taps_clear_nxt = 1'b1;
         end
         default: begin
            w_lms_en_nxt   = 1'b0;
            w_lms_step_nxt = '0;
         end
      endcase
   end

   // State, counters, accumulator and registered outputs.
   always_ff @(posedge clk) begin
      if (!i_reset) begin
         r_state      <= ST_IDLE;
         r_sym_cnt    <= '0;
         r_win_cnt    <= '0;
         r_fine_win   <= '0;
         r_acc        <= '0;
         r_energy     <= '0;
         r_lms_en     <= 1'b0;
         r_lms_step   <= '0;
         r_taps_clear <= 1'b0;
         r_locked     <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_sym_cnt    <= w_sym_cnt_nxt;
         r_win_cnt    <= w_win_cnt_nxt;
         r_fine_win   <= w_fine_win_nxt;
         r_acc        <= w_acc_nxt;
         r_energy     <= w_energy_nxt;
         r_lms_en     <= w_lms_en_nxt;
         r_lms_step   <= w_lms_step_nxt;
         r_taps_clear <= w_taps_clear_nxt;
         r_locked     <= w_locked_nxt;
      end
   end

   assign o_state      = r_state;
   assign o_lms_en     = r_lms_en;
   assign o_lms_step   = r_lms_step;
   assign o_taps_clear = r_taps_clear;
   assign o_locked     = r_locked;
   assign o_err_energy = r_energy;

endmodule
